// File: rtl/conv_frame_loader_if.sv
// Byte-in / result-word-out handshake bundle between the frame loader and its neighbours.
// master = loader side, slave = byte producer / result consumer side.
interface conv_frame_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_data;
  logic        out_last;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/conv_frame_loader.sv
// Loads 9 weights + 25 pixels into the flat buses of the 3x3-over-5x5 convolution array,
// waits out the MAC latency, captures the nine window results and streams them out.
module conv_frame_loader #(
  parameter int MAC_LAT    = 2,
  parameter int HOLD_EXTRA = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  conv_frame_loader_if.master  hs,
  output logic [199:0]         f,
  output logic [71:0]          w,
  input  logic [179:0]         res_win,
  output logic                 busy
);

  localparam int TOTAL = MAC_LAT + HOLD_EXTRA;
  localparam int WCW   = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(TOTAL - 1);

  typedef enum logic [1:0] {S_LOAD_W, S_LOAD_F, S_WAIT, S_EMIT} state_t;

  state_t          r_state;
  logic [4:0]      r_cnt;
  logic [WCW-1:0]  r_wcnt;
  logic [3:0]      r_idx;
  logic [7:0]      r_wt  [9];
  logic [7:0]      r_px  [25];
  logic [19:0]     r_buf [9];
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_out_last;
  logic            r_busy;
  logic [19:0]     r_out_data;

  logic [19:0]     w_res [9];
  logic            w_in_fire;
  logic            w_out_fire;
  logic [3:0]      w_idx_nx;

  assign w_in_fire  = hs.in_valid && r_in_ready;
  assign w_out_fire = r_out_valid && hs.out_ready;
  assign w_idx_nx   = r_idx + 4'd1;

  // Byte slots map onto the array's bus layout: pixels LSB-first, weights MSB-first.
  genvar gi;
  generate
    for (gi = 0; gi < 25; gi++) begin : g_px
      assign f[8*gi +: 8] = r_px[gi];
    end
    for (gi = 0; gi < 9; gi++) begin : g_wt
      assign w[71-8*gi -: 8]  = r_wt[gi];
      assign w_res[gi]        = res_win[20*gi +: 20];
    end
  endgenerate

  assign hs.in_ready  = r_in_ready;
  assign hs.out_valid = r_out_valid;
  assign hs.out_data  = r_out_data;
  assign hs.out_last  = r_out_last;
  assign busy         = r_busy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_LOAD_W;
      r_cnt       <= '0;
      r_wcnt      <= '0;
      r_idx       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        r_wt[i]  <= '0;
        r_buf[i] <= '0;
      end
      for (int i = 0; i < 25; i++) begin
        r_px[i] <= '0;
      end
    end else begin
      case (r_state)
        S_LOAD_W: begin
          r_in_ready <= 1'b1;
          if (w_in_fire) begin
            r_wt[r_cnt[3:0]] <= hs.in_data;
            if (r_cnt == 5'd8) begin
              r_cnt   <= '0;
              r_state <= S_LOAD_F;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        S_LOAD_F: begin
          r_in_ready <= 1'b1;
          if (w_in_fire) begin
            r_px[r_cnt] <= hs.in_data;
            if (r_cnt == 5'd24) begin
              r_cnt      <= '0;
              r_wcnt     <= '0;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
              r_state    <= S_WAIT;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        S_WAIT: begin
          // The buffer decouples the result stream from whatever the array does next.
          if (r_wcnt == WLAST) begin
            r_wcnt      <= '0;
            r_buf       <= w_res;
            r_idx       <= '0;
            r_out_valid <= 1'b1;
            r_out_data  <= w_res[0];
            r_out_last  <= 1'b0;
            r_state     <= S_EMIT;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        S_EMIT: begin
          if (w_out_fire) begin
            if (r_idx == 4'd8) begin
              r_idx       <= '0;
              r_cnt       <= '0;
              r_out_valid <= 1'b0;
              r_out_data  <= '0;
              r_out_last  <= 1'b0;
              r_busy      <= 1'b0;
              r_in_ready  <= 1'b1;
              r_state     <= S_LOAD_W;
            end else begin
              r_idx      <= w_idx_nx;
              r_out_data <= r_buf[w_idx_nx];
              r_out_last <= (w_idx_nx == 4'd8);
            end
          end
        end
        default: r_state <= S_LOAD_W;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_frame_loader.sv
// Frame-level bench: drives byte frames from a vector table, models the convolution array
// behind res_win with a two-stage pipeline, and checks buses, result words and handshakes.
module tb_conv_frame_loader;

  logic          clk;
  logic          reset;
  logic [199:0]  f;
  logic [71:0]   w;
  logic [179:0]  res_win;
  logic          busy;
  logic [179:0]  arr_s1;

  conv_frame_loader_if bus ();

  conv_frame_loader #(.MAC_LAT(2), .HOLD_EXTRA(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .hs      (bus),
    .f       (f),
    .w       (w),
    .res_win (res_win),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Convolution array: window i=3r+c, weight j=3a+b applied to pixel (r+a, c+b).
  function automatic logic [179:0] conv(input logic [199:0] fb, input logic [71:0] wb);
    logic [179:0] r;
    int acc;
    r = '0;
    for (int i = 0; i < 9; i++) begin
      acc = 0;
      for (int a = 0; a < 3; a++)
        for (int b = 0; b < 3; b++)
          acc += int'(fb[8*((i/3+a)*5 + (i%3) + b) +: 8]) * int'(wb[71-8*(3*a+b) -: 8]);
      r[20*i +: 20] = 20'(acc);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    arr_s1  <= conv(f, w);
    res_win <= arr_s1;
  end

  typedef struct packed {
    logic [71:0]       wbus;
    logic [199:0]      fbus;
    logic [8:0][19:0]  exp;
  } vec_t;

  vec_t tab [6];
  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [8:0][19:0] mk9(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5,
                                           input int a6, input int a7, input int a8);
    return {20'(a8), 20'(a7), 20'(a6), 20'(a5), 20'(a4), 20'(a3), 20'(a2), 20'(a1), 20'(a0)};
  endfunction

  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 200'(bus.in_ready), 200'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_bytes(input int v, input int nbytes, input int gap_max);
    for (int n = 0; n < nbytes; n++) begin
      if (n < 9) send_byte(tab[v].wbus[71-8*n -: 8], $urandom_range(0, gap_max));
      else       send_byte(tab[v].fbus[8*(n-9) +: 8], $urandom_range(0, gap_max));
    end
  endtask

  task automatic run_frame(input int v, input int gap_max, input bit bp, input bit junk,
                           input bit chk_busy);
    int got, cyc, busy_n;
    logic stalled, hold_l;
    logic [19:0] hold_d;
    send_bytes(v, 34, gap_max);
    chk("w_bus", 200'(w), 200'(tab[v].wbus));
    chk("f_bus", f, tab[v].fbus);
    got = 0; cyc = 0; busy_n = 0; stalled = 1'b0; hold_d = '0; hold_l = 1'b0;
    if (junk) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hEE;
    end
    while (got < 9 && cyc < 200) begin
      bus.out_ready = bp ? (cyc % 3 == 0) : 1'b1;
      if (stalled) begin
        chk("stall_valid", 200'(bus.out_valid), 200'd1);
        chk("stall_data", 200'(bus.out_data), 200'(hold_d));
        chk("stall_last", 200'(bus.out_last), 200'(hold_l));
      end
      chk("in_ready_busy", 200'(bus.in_ready), 200'd0);
      if (busy) busy_n++;
      stalled = bus.out_valid && !bus.out_ready;
      hold_d  = bus.out_data;
      hold_l  = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("v%0d_word%0d", v, got), 200'(bus.out_data), 200'(tab[v].exp[got]));
        chk($sformatf("v%0d_last%0d", v, got), 200'(bus.out_last), 200'(got == 8));
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    if (got < 9) chk("emit_timeout", 200'(got), 200'd9);
    chk("in_ready_after", 200'(bus.in_ready), 200'd1);
    chk("out_valid_after", 200'(bus.out_valid), 200'd0);
    if (chk_busy) chk("busy_cycles", 200'(busy_n), 200'd12);
    chk("w_kept", 200'(w), 200'(tab[v].wbus));
    chk("f_kept", f, tab[v].fbus);
  endtask

  initial begin
    // Vector table: frame bytes and hand-computed window results.
    tab[0].wbus = {9{8'd1}};
    for (int k = 0; k < 25; k++) tab[0].fbus[8*k +: 8] = 8'(k);
    tab[0].exp  = mk9(54, 63, 72, 99, 108, 117, 144, 153, 162);

    tab[1].wbus = 72'h112233445566778899;
    for (int k = 0; k < 25; k++) tab[1].fbus[8*k +: 8] = 8'(8'hA0 + k);
    tab[1].exp  = mk9(128622, 129387, 130152, 132447, 133212, 133977, 136272, 137037, 137802);

    tab[2].wbus = 72'h00_00_00_00_01_00_00_00_00;
    tab[2].fbus = tab[0].fbus;
    tab[2].exp  = mk9(6, 7, 8, 11, 12, 13, 16, 17, 18);

    tab[3].wbus = 72'h02_00_00_00_00_00_00_00_00;
    tab[3].fbus = tab[0].fbus;
    tab[3].exp  = mk9(0, 2, 4, 10, 12, 14, 20, 22, 24);

    tab[4].wbus = {9{8'hFF}};
    tab[4].fbus = {25{8'hFF}};
    tab[4].exp  = mk9(585225, 585225, 585225, 585225, 585225, 585225, 585225, 585225, 585225);

    tab[5].wbus = '0;
    tab[5].fbus = tab[0].fbus;
    tab[5].exp  = mk9(0, 0, 0, 0, 0, 0, 0, 0, 0);

    reset = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_f", f, 200'd0);
    chk("rst_w", 200'(w), 200'd0);
    chk("rst_out_valid", 200'(bus.out_valid), 200'd0);
    chk("rst_out_data", 200'(bus.out_data), 200'd0);
    chk("rst_out_last", 200'(bus.out_last), 200'd0);
    chk("rst_busy", 200'(busy), 200'd0);
    chk("rst_in_ready", 200'(bus.in_ready), 200'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("in_ready_release", 200'(bus.in_ready), 200'd1);

    // Table-driven frames, applied back to back.
    for (int v = 0; v < 6; v++) begin
      $display("vector %0d: plain frame", v);
      run_frame(v, 0, 1'b0, 1'b0, v == 1);
    end

    // Bus packing boundary bytes.
    $display("packing frame");
    run_frame(1, 0, 1'b0, 1'b0, 1'b1);
    chk("w_pack", 200'(w), 200'(72'h112233445566778899));
    chk("f_lo", 200'(f[7:0]), 200'(8'hA0));
    chk("f_hi", 200'(f[199:192]), 200'(8'hB8));

    $display("backpressure frame");
    run_frame(2, 0, 1'b1, 1'b0, 1'b0);

    $display("input gaps with junk during WAIT/EMIT");
    run_frame(3, 3, 1'b0, 1'b1, 1'b0);
    run_frame(0, 3, 1'b1, 1'b1, 1'b0);

    // Reset after 20 bytes, then a clean frame.
    $display("reset mid-frame");
    send_bytes(4, 20, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_f", f, 200'd0);
    chk("mid_rst_w", 200'(w), 200'd0);
    chk("mid_rst_out_valid", 200'(bus.out_valid), 200'd0);
    chk("mid_rst_out_data", 200'(bus.out_data), 200'd0);
    chk("mid_rst_out_last", 200'(bus.out_last), 200'd0);
    chk("mid_rst_in_ready", 200'(bus.in_ready), 200'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_release", 200'(bus.in_ready), 200'd1);
    run_frame(4, 0, 1'b0, 1'b0, 1'b0);

    $display("back-to-back frames");
    run_frame(5, 0, 1'b0, 1'b0, 1'b0);
    run_frame(2, 0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conv_frame_loader.md
Name: conv_frame_loader

Overview:
- Producer/consumer end of the 3x3-over-5x5 convolution array interface.
- Accepts a byte stream of 9 kernel weights, then 25 feature pixels, over a valid/ready handshake.
- Packs the bytes into the flat feature bus (200 bits) and weight bus (72 bits) that the convolution array consumes, and holds them stable for the array's MAC latency.
- Captures the nine 20-bit window results and streams them out one per handshake.

Parameters:
- MAC_LAT, 2: clock cycles from stable f/w to valid results at the convolution array outputs.
- HOLD_EXTRA, 1: extra settle cycles added before result capture; total wait = MAC_LAT+HOLD_EXTRA.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  input byte valid.
- in_ready  out  1  loader can accept a byte.
- in_data  in  8  weight or pixel byte, unsigned.
- f  out  200  feature bus: pixel k (row-major, k=0..24) at f[8k+7:8k].
- w  out  72  weight bus: weight j (row-major, j=0..8) at w[71-8j:64-8j].
- res_win  in  180  array results: window i=3r+c at [20i+19:20i]. Top-level wiring: result_33→i0, result_32→i1, result_31→i2, result_23→i3, result_22→i4, result_21→i5, result_13→i6, result_12→i7, result_11→i8.
- busy  out  1  high in WAIT and EMIT.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts the result word.
- out_data  out  20  result word, window order i=0..8.
- out_last  out  1  high with window 8.

Behaviour:
- Reset (reset==0 at a clock edge) drives the following, regardless of state, including mid-frame:
  - state=LOAD_W; byte counter=0; wait counter=0; emit index=0.
  - f=0, w=0, out_valid=0, out_data=0, out_last=0, busy=0, in_ready=0.
- in_ready goes 1 the first cycle after reset is released.
- A transfer happens on the input side when in_valid and in_ready are both high, and on the output side when out_valid and out_ready are both high.
- LOAD_W:
  - in_ready=1.
  - Each transfer writes weight slot j=cnt, then cnt increments.
  - The transfer with cnt=8 sets cnt=0 and moves to LOAD_F.
- LOAD_F:
  - in_ready=1.
  - Each transfer writes f slot k=cnt, then cnt increments.
  - The transfer with cnt=24 moves to WAIT with wcnt=0.
  - in_ready drops the cycle after that final byte.
- WAIT:
  - in_ready=0; f and w held constant.
  - wcnt increments every cycle.
  - When wcnt==MAC_LAT+HOLD_EXTRA-1, all 180 bits of res_win are latched into a capture buffer and the block moves to EMIT.
- EMIT:
  - out_valid=1; out_data=buffer[idx]; out_last=(idx==8).
  - On each output transfer idx increments.
  - The transfer at idx 8 returns the block to LOAD_W with idx=0, cnt=0 and out_valid=0 on the next cycle.
  - out_data/out_last hold steady while out_valid=1 and out_ready=0.
  - f and w keep their values until they are overwritten by the next frame's bytes. The buffer isolates the output from array changes.
- in_valid while in_ready=0 is ignored; no byte is consumed.
- Bytes of a partial frame stay in f/w. There is no timeout.
- Stalls on in_valid within a frame are allowed at any byte.
- No arithmetic is done in the block; result words pass through unchanged (20 bits, unsigned).
- Throughput: 34 input cycles + wait + 9 output cycles per frame, minimum 34+MAC_LAT+HOLD_EXTRA+9 cycles.

Test Plan:
- Loopback with the convolution array. Weights all 1; pixels 0..24.
  - Expect out_data sequence 54,63,72,99,108,117,144,153,162; out_last only on the 9th word.
- Bus packing.
  - Weights 0x11..0x99; pixels 0xA0+k.
  - After the 34th byte expect w=0x112233445566778899, f[7:0]=0xA0, f[199:192]=0xB8.
  - busy=1 and in_ready=0 for exactly MAC_LAT+HOLD_EXTRA+9 output-ready cycles.
- Output backpressure: toggle out_ready 1,0,0,1,…
  - Exactly 9 words are emitted, in order, with no duplicates or drops.
  - Data is stable during stalls.
  - in_ready stays 0 until the last output handshake.
- Input gaps: random in_valid gaps, in_valid asserted during WAIT/EMIT.
  - Bytes offered while in_ready=0 are not consumed; results match the gap-free run.
- Reset mid-frame: assert reset after 20 input bytes, then send a full frame.
  - f/w/out_* read 0 the cycle after reset; the new frame yields the correct 9 results.
- Back-to-back frames: send frame 2 immediately after frame 1's out_last.
  - Frame-2 results match frame 2's data only.
